// File: rtl/execute_stage.sv
// Execute stage of the five-stage pipeline.
// Decodes the D/X instruction, bypasses operands from M and W, drives the
// external ALU, and registers the ALU outcome into the X/M latch together
// with any branch redirect.
module execute_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        m_wr,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_data,
    input  logic        w_wr,
    input  logic [4:0]  w_rd,
    input  logic [31:0] w_data,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_ne,
    input  logic        alu_lt,
    input  logic        alu_ovf,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_result,
    output logic [31:0] out_store,
    output logic [4:0]  out_rd,
    output logic        out_wr,
    output logic        br_taken,
    output logic [31:0] br_target
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;

    localparam logic [4:0] OVF_REG  = 5'd30;

    // Instruction fields
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [31:0] imm;

    assign opcode = in_insn[31:27];
    assign rd     = in_insn[26:22];
    assign rs     = in_insn[21:17];
    assign rt     = in_insn[16:12];
    assign shamt  = in_insn[11:7];
    assign aluop  = in_insn[6:2];
    assign imm    = {{15{in_insn[16]}}, in_insn[16:0]};

    // Bypass: register zero reads 0, M is newer than W, otherwise regfile.
    function automatic logic [31:0] bypass(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0)
            return 32'd0;
        else if (m_wr && (m_rd == r))
            return m_data;
        else if (w_wr && (w_rd == r))
            return w_data;
        else
            return rf;
    endfunction

    logic is_rtype, is_addi, is_lw, is_sw, is_bne, is_blt, is_branch;

    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_addi   = (opcode == OP_ADDI);
    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_bne    = (opcode == OP_BNE);
    assign is_blt    = (opcode == OP_BLT);
    assign is_branch = is_bne || is_blt;

    // Second source is rd for branches and stores (the value compared or
    // stored), rt for everything else; in_b carries whichever one it is.
    logic [4:0]  src2;
    logic [31:0] rs_val;
    logic [31:0] src2_val;

    assign src2     = (is_branch || is_sw) ? rd : rt;
    assign rs_val   = bypass(rs, in_a);
    assign src2_val = bypass(src2, in_b);

    assign in_ready = !stall;

    // ALU operand and opcode selection by instruction class
    always_comb begin
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_op    = ALU_ADD;
        alu_shamt = 5'd0;
        if (is_rtype) begin
            alu_a     = rs_val;
            alu_b     = src2_val;
            alu_op    = aluop;
            alu_shamt = shamt;
        end else if (is_addi || is_lw || is_sw) begin
            alu_a = rs_val;
            alu_b = imm;
        end else if (is_branch) begin
            alu_a  = src2_val;
            alu_b  = rs_val;
            alu_op = ALU_SUB;
        end
    end

    // Next X/M contents, including overflow redirection to r30
    logic        next_valid;
    logic [31:0] next_result;
    logic [31:0] next_store;
    logic [4:0]  next_rd;
    logic        next_wr;
    logic        next_taken;
    logic [31:0] next_target;

    always_comb begin
        logic [31:0] ovf_code;
        logic        writes;
        ovf_code = 32'd0;
        if (is_rtype && (aluop == ALU_ADD))
            ovf_code = 32'd1;
        else if (is_addi)
            ovf_code = 32'd2;
        else if (is_rtype && (aluop == ALU_SUB))
            ovf_code = 32'd3;

        writes      = is_rtype || is_addi || is_lw;
        next_valid  = in_valid && !flush;
        next_result = alu_result;
        next_rd     = writes ? rd : 5'd0;
        next_wr     = writes;
        next_store  = is_sw ? src2_val : 32'd0;
        next_target = in_pc + 32'd1 + imm;
        next_taken  = (is_bne && alu_ne) || (is_blt && alu_lt);

        if (alu_ovf && (ovf_code != 32'd0)) begin
            next_result = ovf_code;
            next_rd     = OVF_REG;
            next_wr     = 1'b1;
        end

        if (!next_valid) begin
            next_wr    = 1'b0;
            next_taken = 1'b0;
        end
    end

    logic wr_q;
    logic taken_q;

    // X/M register: loads whenever not stalled, cleared asynchronously by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_pc     <= 32'd0;
            out_result <= 32'd0;
            out_store  <= 32'd0;
            out_rd     <= 5'd0;
            wr_q       <= 1'b0;
            taken_q    <= 1'b0;
            br_target  <= 32'd0;
        end else if (!stall) begin
            out_valid  <= next_valid;
            out_pc     <= in_pc;
            out_result <= next_result;
            out_store  <= next_store;
            out_rd     <= next_rd;
            wr_q       <= next_wr;
            taken_q    <= next_taken;
            br_target  <= next_target;
        end
    end

    assign out_wr   = wr_q && out_valid;
    assign br_taken = taken_q && out_valid;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a small behavioural ALU attached.
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_insn, in_a, in_b;
    logic        m_wr, w_wr;
    logic [4:0]  m_rd, w_rd;
    logic [31:0] m_data, w_data;
    logic        stall, flush;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_op, alu_shamt;
    logic        alu_ne, alu_lt, alu_ovf;
    logic        out_valid, out_wr, br_taken;
    logic [31:0] out_pc, out_result, out_store, br_target;
    logic [4:0]  out_rd;

    int total = 0;
    int fails = 0;

    execute_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_insn(in_insn), .in_a(in_a), .in_b(in_b),
        .m_wr(m_wr), .m_rd(m_rd), .m_data(m_data),
        .w_wr(w_wr), .w_rd(w_rd), .w_data(w_data),
        .stall(stall), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf),
        .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result),
        .out_store(out_store), .out_rd(out_rd), .out_wr(out_wr),
        .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: op 0 adds, op 1 subtracts, flags from the operands
    logic [31:0] sum, diff;
    assign sum        = alu_a + alu_b;
    assign diff       = alu_a - alu_b;
    assign alu_result = (alu_op == 5'd1) ? diff : sum;
    assign alu_ne     = (alu_a != alu_b);
    assign alu_lt     = ($signed(alu_a) < $signed(alu_b));
    assign alu_ovf    = (alu_op == 5'd1)
                        ? ((alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]))
                        : ((alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]));

    function automatic logic [31:0] r_insn(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_insn(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                                  input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_pc    = pc;
        in_insn  = insn;
        in_a     = a;
        in_b     = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        m_wr = 1'b0; m_rd = 5'd0; m_data = 32'd0;
        w_wr = 1'b0; w_rd = 5'd0; w_data = 32'd0;
        apply_stimulus(1'b1, 32'h40, r_insn(5'd5, 5'd3, 5'd4, 5'd0), 32'd7, 32'd5);
        tick();
        tick();
        check_output("reset_valid", 32'(out_valid), 32'd0);
        check_output("reset_result", out_result, 32'd0);
        check_output("reset_ready", 32'(in_ready), 32'd1);

        // R-type add with no bypass
        @(negedge clock);
        reset = 1'b0;
        apply_stimulus(1'b1, 32'h20, r_insn(5'd5, 5'd3, 5'd4, 5'd0), 32'd7, 32'd5);
        check_output("radd_alu_a", alu_a, 32'd7);
        check_output("radd_alu_b", alu_b, 32'd5);
        tick();
        check_output("radd_result", out_result, 32'd12);
        check_output("radd_rd", 32'(out_rd), 32'd5);
        check_output("radd_wr", 32'(out_wr), 32'd1);
        check_output("radd_valid", 32'(out_valid), 32'd1);
        check_output("radd_pc", out_pc, 32'h20);

        // Bypass priority
        m_wr = 1'b1; m_rd = 5'd3; m_data = 32'd100;
        w_wr = 1'b1; w_rd = 5'd3; w_data = 32'd200;
        apply_stimulus(1'b1, 32'h21, r_insn(5'd5, 5'd3, 5'd4, 5'd0), 32'd7, 32'd5);
        check_output("byp_m_prio", alu_a, 32'd100);
        m_wr = 1'b0;
        apply_stimulus(1'b1, 32'h21, r_insn(5'd5, 5'd3, 5'd4, 5'd0), 32'd7, 32'd5);
        check_output("byp_w", alu_a, 32'd200);
        m_wr = 1'b1; m_rd = 5'd4;
        apply_stimulus(1'b1, 32'h21, r_insn(5'd5, 5'd3, 5'd4, 5'd0), 32'd7, 32'd5);
        check_output("byp_rt_m", alu_b, 32'd100);
        m_rd = 5'd0; w_rd = 5'd0;
        apply_stimulus(1'b1, 32'h21, r_insn(5'd5, 5'd0, 5'd4, 5'd0), 32'd7, 32'd5);
        check_output("byp_r0", alu_a, 32'd0);
        m_wr = 1'b0; w_wr = 1'b0;

        // addi overflow redirects to r30 with code 2
        apply_stimulus(1'b1, 32'h30, i_insn(5'b00101, 5'd7, 5'd2, 17'd1), 32'h7FFFFFFF, 32'd0);
        check_output("addi_alu_b", alu_b, 32'd1);
        tick();
        check_output("ovf_rd", 32'(out_rd), 32'd30);
        check_output("ovf_result", out_result, 32'd2);
        check_output("ovf_wr", 32'(out_wr), 32'd1);

        // sw: store data is the rd value, no write-back
        apply_stimulus(1'b1, 32'h31, i_insn(5'b00111, 5'd6, 5'd1, 17'd8), 32'd100, 32'd55);
        tick();
        check_output("sw_store", out_store, 32'd55);
        check_output("sw_addr", out_result, 32'd108);
        check_output("sw_wr", 32'(out_wr), 32'd0);

        // blt taken: -1 < 2
        apply_stimulus(1'b1, 32'h10, i_insn(5'b00110, 5'd1, 5'd2, 17'h1FFFC), 32'd2, 32'hFFFFFFFF);
        check_output("blt_alu_a", alu_a, 32'hFFFFFFFF);
        check_output("blt_alu_op", 32'(alu_op), 32'd1);
        tick();
        check_output("blt_taken", 32'(br_taken), 32'd1);
        check_output("blt_target", br_target, 32'h0000000D);
        check_output("blt_wr", 32'(out_wr), 32'd0);
        apply_stimulus(1'b0, 32'h11, 32'd0, 32'd0, 32'd0);
        tick();
        check_output("blt_pulse_end", 32'(br_taken), 32'd0);

        // bne with equal operands is not taken
        apply_stimulus(1'b1, 32'h10, i_insn(5'b00010, 5'd1, 5'd2, 17'h1FFFC), 32'd9, 32'd9);
        tick();
        check_output("bne_eq_taken", 32'(br_taken), 32'd0);
        check_output("bne_valid", 32'(out_valid), 32'd1);

        // Unknown opcode passes through without write or branch
        apply_stimulus(1'b1, 32'h50, 32'hF8000000, 32'd1, 32'd1);
        check_output("unk_alu_op", 32'(alu_op), 32'd0);
        tick();
        check_output("unk_valid", 32'(out_valid), 32'd1);
        check_output("unk_wr", 32'(out_wr), 32'd0);

        // Stall holds outputs for three cycles, flush under stall ignored
        apply_stimulus(1'b1, 32'h60, r_insn(5'd4, 5'd3, 5'd4, 5'd0), 32'd1, 32'd2);
        tick();
        check_output("cap_result", out_result, 32'd3);
        stall = 1'b1;
        apply_stimulus(1'b1, 32'h61, r_insn(5'd9, 5'd3, 5'd4, 5'd0), 32'd50, 32'd60);
        check_output("stall_ready", 32'(in_ready), 32'd0);
        check_output("stall_alu_a", alu_a, 32'd50);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) flush = 1'b1;
            tick();
            check_output("stall_result", out_result, 32'd3);
            check_output("stall_rd", 32'(out_rd), 32'd4);
            check_output("stall_pc", out_pc, 32'h60);
        end
        check_output("stall_flush_valid", 32'(out_valid), 32'd1);
        stall = 1'b0;
        apply_stimulus(1'b1, 32'h62, r_insn(5'd9, 5'd3, 5'd4, 5'd0), 32'd50, 32'd60);
        tick();
        check_output("flush_valid", 32'(out_valid), 32'd0);
        check_output("flush_wr", 32'(out_wr), 32'd0);
        flush = 1'b0;

        // Asynchronous reset between edges with a taken branch held
        apply_stimulus(1'b1, 32'h10, i_insn(5'b00110, 5'd1, 5'd2, 17'h1FFFC), 32'd2, 32'hFFFFFFFF);
        tick();
        check_output("pre_rst_taken", 32'(br_taken), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("arst_valid", 32'(out_valid), 32'd0);
        check_output("arst_taken", 32'(br_taken), 32'd0);
        check_output("arst_target", br_target, 32'd0);
        check_output("arst_pc", out_pc, 32'd0);
        check_output("arst_rd", 32'(out_rd), 32'd0);
        reset = 1'b0;
        apply_stimulus(1'b1, 32'h70, r_insn(5'd5, 5'd3, 5'd4, 5'd0), 32'd7, 32'd5);
        check_output("post_rst_still0", 32'(out_valid), 32'd0);
        tick();
        check_output("post_rst_valid", 32'(out_valid), 32'd1);
        check_output("post_rst_result", out_result, 32'd12);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
